// File: rtl/serial_addsub_if.sv
// Requester/consumer bundle for the bit-serial adder/subtractor.
// The requester drives the operation; the arithmetic unit returns status and result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output start, mode, A, B, Cin,
        input  busy, done, Sum, Cout, Ovf
    );

    modport slave (
        input  start, mode, A, B, Cin,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one registered full-adder cell, LSB first.
// Subtraction is A + ~B + ~Cin, so Cout=1 means no borrow.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             s_bit;
    logic             c_bit;

    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The single full-adder cell.
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_bit    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign res_next = {s_bit, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                a_sh  <= bus.A;
                b_sh  <= bus.mode ? ~bus.B : bus.B;
                carry <= bus.mode ? ~bus.Cin : bus.Cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_next;
                carry  <= c_bit;
                cnt    <= cnt + CNT_W'(1);
                if (last) begin
                    sum_q  <= res_next;
                    cout_q <= c_bit;
                    // carry still holds the carry into the MSB on the last bit
                    ovf_q  <= carry ^ c_bit;
                end
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed test of serial_addsub at WIDTH=8 plus an exhaustive WIDTH=4 sweep
// against an arithmetic model built from signed/unsigned integer math.
module tb_serial_addsub;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    serial_addsub_if #(.WIDTH(8)) b8 ();
    serial_addsub_if #(.WIDTH(4)) b4 ();

    serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done, checking busy stays high and Sum holds meanwhile.
    task automatic wait_done8(input string tag, input int exp_lat, input logic [7:0] held);
        int  k;
        bit  busy_ok;
        bit  held_ok;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (b8.done) break;
            if (!b8.busy) busy_ok = 1'b0;
            if (b8.Sum !== held) held_ok = 1'b0;
        end
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_busy_during_run"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_sum_held"}, {31'd0, held_ok}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, b8.busy}, 32'd0);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic mode,
                       input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        logic [7:0] held;
        held     = b8.Sum;
        b8.A     = a;
        b8.B     = b;
        b8.Cin   = cin;
        b8.mode  = mode;
        b8.start = 1'b1;
        tick();
        b8.start = 1'b0;
        b8.A     = 8'hxx;
        b8.B     = 8'hxx;
        chk({tag, "_busy_start"}, {31'd0, b8.busy}, 32'd1);
        wait_done8(tag, 8, held);
        chk({tag, "_sum"}, {24'd0, b8.Sum}, {24'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, b8.Cout}, {31'd0, exp_cout});
        chk({tag, "_ovf"}, {31'd0, b8.Ovf}, {31'd0, exp_ovf});
        tick();
        chk({tag, "_done_drop"}, {31'd0, b8.done}, 32'd0);
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, "_busy"}, {31'd0, b8.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, b8.done}, 32'd0);
        chk({tag, "_sum"}, {24'd0, b8.Sum}, 32'd0);
        chk({tag, "_cout"}, {31'd0, b8.Cout}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, b8.Ovf}, 32'd0);
    endtask

    initial begin
        bit saw_done;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        b8.start = 1'b0; b8.mode = 1'b0; b8.A = '0; b8.B = '0; b8.Cin = 1'b0;
        b4.start = 1'b0; b4.mode = 1'b0; b4.A = '0; b4.B = '0; b4.Cin = 1'b0;

        // Power-up reset, checked before any clock edge.
        #1;
        chk_reset8("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic add.
        op8("add_3c_05", 8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);

        // Asynchronous reset while idle, mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset8("idle_rst");
        tick();
        rst_n = 1'b1;
        tick();

        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8("sub_05_03", 8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);

        // Start pulsed mid-run is ignored.
        b8.A = 8'h01; b8.B = 8'h02; b8.Cin = 1'b0; b8.mode = 1'b0; b8.start = 1'b1;
        tick();
        b8.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) begin
                b8.A = 8'h01; b8.B = 8'h01; b8.Cin = 1'b1; b8.start = 1'b1;
            end
            if (k == 4) b8.start = 1'b0;
            if (k == 4) chk("ign_busy", {31'd0, b8.busy}, 32'd1);
            if (k == 5) chk("ign_sum_held", {24'd0, b8.Sum}, 32'h01);
        end
        chk("ign_done", {31'd0, b8.done}, 32'd1);
        chk("ign_sum", {24'd0, b8.Sum}, 32'h03);
        tick();
        chk("ign_no_restart", {31'd0, b8.busy}, 32'd0);

        // Start held through the done cycle: back-to-back operations.
        b8.A = 8'h01; b8.B = 8'h01; b8.Cin = 1'b0; b8.mode = 1'b0; b8.start = 1'b1;
        tick();
        b8.start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 7) begin
                b8.A = 8'h11; b8.B = 8'h22; b8.Cin = 1'b0; b8.mode = 1'b0; b8.start = 1'b1;
            end
            if (k == 8) begin
                chk("b2b_first_done", {31'd0, b8.done}, 32'd1);
                chk("b2b_first_sum", {24'd0, b8.Sum}, 32'h02);
            end
        end
        b8.start = 1'b0;
        chk("b2b_second_busy", {31'd0, b8.busy}, 32'd1);
        chk("b2b_done_low", {31'd0, b8.done}, 32'd0);
        wait_done8("b2b_second", 8, 8'h02);
        chk("b2b_second_sum", {24'd0, b8.Sum}, 32'h33);
        tick();

        // Reset during cycle 4 of a run: everything clears, no done follows.
        b8.A = 8'hAA; b8.B = 8'h11; b8.Cin = 1'b0; b8.mode = 1'b0; b8.start = 1'b1;
        tick();
        b8.start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset8("run_rst");
        tick();
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (b8.done || b8.busy) saw_done = 1'b1;
        end
        chk("run_rst_no_done", {31'd0, saw_done}, 32'd0);
        op8("add_0a_0b", 8'h0A, 8'h0B, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0);

        // Exhaustive WIDTH=4 sweep against integer arithmetic.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int c = 0; c < 2; c++) begin
                        int  sa;
                        int  sb;
                        int  r;
                        int  k;
                        logic [3:0] e_sum;
                        logic       e_cout;
                        logic       e_ovf;
                        sa = (a > 7) ? a - 16 : a;
                        sb = (b > 7) ? b - 16 : b;
                        if (m == 0) begin
                            r      = sa + sb + c;
                            e_cout = ((a + b + c) > 15);
                        end else begin
                            r      = sa - sb - c;
                            e_cout = (a >= b + c);
                        end
                        e_sum = 4'(r);
                        e_ovf = (r < -8) || (r > 7);
                        b4.A = 4'(a); b4.B = 4'(b); b4.Cin = c[0]; b4.mode = m[0];
                        b4.start = 1'b1;
                        tick();
                        b4.start = 1'b0;
                        k = 0;
                        while (k < 20 && !b4.done) begin
                            tick();
                            k++;
                        end
                        if (k != 4) chk($sformatf("w4_lat_m%0d_a%0h_b%0h_c%0d", m, a, b, c), k, 4);
                        chk($sformatf("w4_sum_m%0d_a%0h_b%0h_c%0d", m, a, b, c), {28'd0, b4.Sum}, {28'd0, e_sum});
                        chk($sformatf("w4_cout_m%0d_a%0h_b%0h_c%0d", m, a, b, c), {31'd0, b4.Cout}, {31'd0, e_cout});
                        chk($sformatf("w4_ovf_m%0d_a%0h_b%0h_c%0d", m, a, b, c), {31'd0, b4.Ovf}, {31'd0, e_ovf});
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
